// File: rtl/udp_sched_pkg.sv
// Shared types and constants for the UDP reference-clock scheduler.
package udp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } sched_state_e;

  // Smallest period that lets the FSM leave IDLE.
  localparam int unsigned PERIOD_MIN = 1;

  // Idle threshold lanes are all-ones so (counter > condition) stays low.
  localparam logic THRESH_FILL = 1'b1;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/udp_sched_shadow.sv
// One channel's shadow/active threshold pair; active loads from shadow on commit.
module udp_sched_shadow
  import udp_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             commit,
  input  logic             blank,
  output logic [CNT_W-1:0] active
);

  logic [CNT_W-1:0] shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= {CNT_W{THRESH_FILL}};
      active <= {CNT_W{THRESH_FILL}};
    end else begin
      if (wr_en)
        shadow <= wr_data;
      // blank beats commit so lanes are forced low whenever the FSM drops to IDLE
      if (blank)
        active <= {CNT_W{THRESH_FILL}};
      else if (commit)
        active <= shadow;
    end
  end

endmodule

// File: rtl/udp_clk_scheduler.sv
// Period counter, FSM and config handshake for the UDP clock comparators.
// Optional macro UDP_SCHED_ONESHOT_EN adds the oneshot input (single-period run).
module udp_clk_scheduler
  import udp_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CNT_W  = 32,
  localparam int unsigned SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
`ifdef UDP_SCHED_ONESHOT_EN
  input  logic                    oneshot,
`endif
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic                    cfg_is_period,
  input  logic [CNT_W-1:0]        cfg_data,
  output logic [CNT_W-1:0]        counter,
  output logic [NUM_CH*CNT_W-1:0] condition,
  output logic                    period_tick,
  output logic                    busy
);

  sched_state_e     state, state_n;
  logic [CNT_W-1:0] period, period_n, period_sh, counter_n;
  logic             pending, commit, blank, tick_n, cfg_accept, oneshot_go;
  logic [NUM_CH-1:0] wr_ch;

`ifdef UDP_SCHED_ONESHOT_EN
  assign oneshot_go = oneshot;
`else
  assign oneshot_go = 1'b0;
`endif

  assign cfg_accept = cfg_valid && cfg_ready;

  // period_tick is registered one cycle ahead, so it marks the wrap cycle directly
  always_comb begin
    state_n   = state;
    counter_n = counter;
    period_n  = period;
    commit    = 1'b0;
    blank     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop && (period_sh >= CNT_W'(PERIOD_MIN))) begin
          commit    = 1'b1;
          period_n  = period_sh;
          counter_n = '0;
          state_n   = oneshot_go ? STOPPING : RUN;
        end
      end
      RUN, STOPPING: begin
        if (period_tick) begin
          counter_n = '0;
          if (state == STOPPING || stop) begin
            state_n = IDLE;
            blank   = 1'b1;
          end else if (pending) begin
            commit   = 1'b1;
            period_n = period_sh;
            if (period_sh == '0) begin
              state_n = IDLE;
              blank   = 1'b1;
            end
          end
        end else begin
          counter_n = counter + 1'b1;
          if (state == RUN && stop)
            state_n = STOPPING;
        end
      end
      default: begin
        state_n = IDLE;
        blank   = 1'b1;
      end
    endcase
    tick_n = (state_n != IDLE) && (counter_n == period_n - 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      period      <= '0;
      period_sh   <= '0;
      pending     <= 1'b0;
      period_tick <= 1'b0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      counter     <= counter_n;
      period      <= period_n;
      pending     <= (pending && !commit) || cfg_accept;
      period_tick <= tick_n;
      cfg_ready   <= !tick_n;
      busy        <= (state_n != IDLE);
      if (cfg_accept && cfg_is_period)
        period_sh <= cfg_data;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch[i] = cfg_accept && !cfg_is_period && (cfg_sel == SEL_W'(i));

    udp_sched_shadow #(
      .CNT_W (CNT_W)
    ) u_shadow (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_ch[i]),
      .wr_data (cfg_data),
      .commit  (commit),
      .blank   (blank),
      .active  (condition[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_udp_clk_scheduler.sv
// Directed self-checking bench for udp_clk_scheduler (3 channels, 8-bit counter).
module tb_udp_clk_scheduler;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
`ifdef UDP_SCHED_ONESHOT_EN
  logic                    oneshot = 1'b0;
`endif
  logic                    cfg_valid = 1'b0;
  logic                    cfg_ready;
  logic [1:0]              cfg_sel = '0;
  logic                    cfg_is_period = 1'b0;
  logic [CNT_W-1:0]        cfg_data = '0;
  logic [CNT_W-1:0]        counter;
  logic [NUM_CH*CNT_W-1:0] condition;
  logic                    period_tick;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;

  udp_clk_scheduler #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
`ifdef UDP_SCHED_ONESHOT_EN
    .oneshot       (oneshot),
`endif
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_sel       (cfg_sel),
    .cfg_is_period (cfg_is_period),
    .cfg_data      (cfg_data),
    .counter       (counter),
    .condition     (condition),
    .period_tick   (period_tick),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic is_period, input logic [1:0] sel, input logic [7:0] data);
    check("cfg_ready_before_write", 64'(cfg_ready), 64'd1);
    cfg_valid     = 1'b1;
    cfg_is_period = is_period;
    cfg_sel       = sel;
    cfg_data      = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [63:0] lanes(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2);
    return 64'({l2, l1, l0});
  endfunction

  initial begin
    step(2);
    // reset values
    check("rst_counter", 64'(counter), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tick", 64'(period_tick), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_lanes", 64'(condition), lanes(8'hFF, 8'hFF, 8'hFF));
    reset = 1'b0;
    step();

    // start with period shadow still 0 is ignored
    pulse_start();
    check("start_p0_busy", 64'(busy), 64'd0);

    cfg_write(1'b1, 2'd0, 8'd10);
    cfg_write(1'b0, 2'd0, 8'd4);
    cfg_write(1'b0, 2'd1, 8'd7);
    pulse_start();
    check("run_busy", 64'(busy), 64'd1);
    check("run_lanes", 64'(condition), lanes(8'd4, 8'd7, 8'hFF));
    for (int k = 0; k < 20; k++) begin
      check("run_counter", 64'(counter), 64'(k % 10));
      check("run_tick", 64'(period_tick), 64'((k % 10) == 9));
      check("run_ready", 64'(cfg_ready), 64'((k % 10) != 9));
      step();
    end

    // threshold write mid-period lands at the wrap
    step(3);
    check("wr_at_3", 64'(counter), 64'd3);
    cfg_write(1'b0, 2'd0, 8'd2);
    check("lane0_held", 64'(condition), lanes(8'd4, 8'd7, 8'hFF));
    step(5);
    check("wrap_counter", 64'(counter), 64'd9);
    check("wrap_ready_low", 64'(cfg_ready), 64'd0);
    check("lane0_still_old", 64'(condition), lanes(8'd4, 8'd7, 8'hFF));
    step();
    check("commit_counter", 64'(counter), 64'd0);
    check("commit_lane0", 64'(condition), lanes(8'd2, 8'd7, 8'hFF));

    // stop at counter 5 finishes the period
    step(5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stopping_busy", 64'(busy), 64'd1);
    step(3);
    check("stopping_last", 64'(counter), 64'd9);
    check("stopping_tick", 64'(period_tick), 64'd1);
    step();
    check("stopped_busy", 64'(busy), 64'd0);
    check("stopped_counter", 64'(counter), 64'd0);
    check("stopped_lanes", 64'(condition), lanes(8'hFF, 8'hFF, 8'hFF));
    check("stopped_ready", 64'(cfg_ready), 64'd1);

    // restart uses latest shadows
    pulse_start();
    check("restart_lanes", 64'(condition), lanes(8'd2, 8'd7, 8'hFF));
    check("restart_busy", 64'(busy), 64'd1);

    // start+stop together in RUN acts as stop
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step(8);
    check("ss_run_busy", 64'(busy), 64'd1);
    step();
    check("ss_run_stopped", 64'(busy), 64'd0);

    // start+stop together in IDLE does nothing
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_idle_busy", 64'(busy), 64'd0);
    check("ss_idle_counter", 64'(counter), 64'd0);

    // committing period 0 drops to IDLE
    pulse_start();
    cfg_write(1'b1, 2'd0, 8'd0);
    step(8);
    check("p0_pre_wrap", 64'(counter), 64'd9);
    check("p0_pre_busy", 64'(busy), 64'd1);
    step();
    check("p0_idle_busy", 64'(busy), 64'd0);
    check("p0_idle_counter", 64'(counter), 64'd0);
    pulse_start();
    check("p0_start_ignored", 64'(busy), 64'd0);

    // asynchronous reset mid-run
    cfg_write(1'b1, 2'd0, 8'd10);
    pulse_start();
    step(6);
    check("pre_reset_counter", 64'(counter), 64'd6);
    reset = 1'b1;
    #1;
    check("async_counter", 64'(counter), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_lanes", 64'(condition), lanes(8'hFF, 8'hFF, 8'hFF));
    step();
    reset = 1'b0;
    pulse_start();
    check("post_reset_start", 64'(busy), 64'd0);

    // maximum period 2^8-1, plus a dropped out-of-range channel write
    cfg_write(1'b1, 2'd0, 8'd255);
    cfg_write(1'b0, 2'd2, 8'd100);
    cfg_write(1'b0, 2'd3, 8'h11);
    pulse_start();
    check("max_lanes", 64'(condition), lanes(8'hFF, 8'hFF, 8'd100));
    step(253);
    check("max_253", 64'(counter), 64'd253);
    check("max_253_tick", 64'(period_tick), 64'd0);
    step();
    check("max_254", 64'(counter), 64'd254);
    check("max_254_tick", 64'(period_tick), 64'd1);
    step();
    check("max_wrap", 64'(counter), 64'd0);
    check("max_wrap_tick", 64'(period_tick), 64'd0);
    check("max_wrap_busy", 64'(busy), 64'd1);

    // period 1: every cycle is a wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_write(1'b1, 2'd0, 8'd1);
    pulse_start();
    check("p1_tick", 64'(period_tick), 64'd1);
    check("p1_ready", 64'(cfg_ready), 64'd0);
    step();
    check("p1_counter", 64'(counter), 64'd0);
    check("p1_tick2", 64'(period_tick), 64'd1);

`ifdef UDP_SCHED_ONESHOT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_write(1'b1, 2'd0, 8'd3);
    start   = 1'b1;
    oneshot = 1'b1;
    step();
    start   = 1'b0;
    oneshot = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("os_busy", 64'(busy), 64'd1);
      check("os_counter", 64'(counter), 64'(k));
      check("os_tick", 64'(period_tick), 64'(k == 2));
      step();
    end
    check("os_done_busy", 64'(busy), 64'd0);
    check("os_done_tick", 64'(period_tick), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
